// File: rtl/memory_unit.sv
// memory_unit: MAR, MDR and 2^ADDR_W x DATA_W RAM memory stage with a post-reset clear and a programming port
module memory_unit #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  input  logic              addr_load_n,
  input  logic              mem_load_n,
  input  logic              ram_en_n,
  input  logic              ram_load_n,
  input  logic              prog_mode,
  input  logic              prog_valid,
  output logic              prog_ready,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic              busy,
  output logic [ADDR_W-1:0] mar_out
);
  localparam logic [1:0] CLEAR = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PROG  = 2'd2;
  logic [1:0]        state_q, state_d, mode_tgt;
  logic [ADDR_W-1:0] clr_q, clr_d, mar_q, mar_d, wa;
  logic [DATA_W-1:0] mdr_q, mdr_d, wd;
  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic              clear, run, prog, we;
  assign clear = state_q == CLEAR;
  assign run   = state_q == RUN;
  assign prog  = state_q == PROG;
  assign mode_tgt = prog_mode ? PROG : RUN;
  // Next state: RUN and PROG both follow prog_mode; CLEAR leaves after its last address; stray encodings restart the clear
  always_comb begin
    state_d = clear ? (&clr_q ? mode_tgt : CLEAR) : (run || prog) ? mode_tgt : CLEAR;
    clr_d   = clear ? clr_q + ADDR_W'(1'b1) : '0;
    mar_d   = (run && !addr_load_n) ? bus_in[ADDR_W-1:0] : mar_q;
    mdr_d   = (run && !mem_load_n) ? bus_in : mdr_q;
    we      = !rst && (clear || (run && !ram_load_n) || (prog && prog_valid));
    wa      = clear ? clr_q : prog ? prog_addr : mar_q;
    wd      = clear ? '0 : prog ? prog_data : mdr_q;
  end
  // Control registers; MAR and MDR only move in RUN
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      clr_q   <= '0;
      mar_q   <= '0;
      mdr_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
    end
  end
  // Single write port shared by clear, programming and RUN stores (stores use pre-edge MAR/MDR)
  always_ff @(posedge clk) begin
    if (we) mem_q[wa] <= wd;
  end
  assign bus_oe     = run && !ram_en_n;
  assign bus_out    = bus_oe ? mem_q[mar_q] : '0;
  assign prog_ready = prog;
  assign busy       = clear;
  assign mar_out    = mar_q;
endmodule

// File: tb/tb_memory_unit.sv
// tb_memory_unit: directed, table-driven and randomized checks of memory_unit against a behavioural model
module tb_memory_unit;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] bus_in, bus_out, prog_data;
  logic       bus_oe, addr_load_n, mem_load_n, ram_en_n, ram_load_n;
  logic       prog_mode, prog_valid, prog_ready, busy;
  logic [3:0] prog_addr, mar_out;
  int checks = 0;
  int failures = 0;
  int         m_mode = 0;
  logic [3:0] m_cnt = 4'h0;
  logic [3:0] m_mar = 4'h0;
  logic [7:0] m_mdr = 8'h00;
  logic [7:0] m_ram [16];
  typedef struct {logic [3:0] addr; logic [7:0] data;} vec_t;
  vec_t wr_tbl[4];
  vec_t rd_tbl[6];

  always #5 clk = ~clk;

  memory_unit #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe),
    .addr_load_n(addr_load_n), .mem_load_n(mem_load_n), .ram_en_n(ram_en_n),
    .ram_load_n(ram_load_n), .prog_mode(prog_mode), .prog_valid(prog_valid),
    .prog_ready(prog_ready), .prog_addr(prog_addr), .prog_data(prog_data),
    .busy(busy), .mar_out(mar_out)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // mode 0 = clearing, 1 = running, 2 = programming
  task automatic model_edge();
    if (rst) begin
      m_mode = 0; m_cnt = 4'h0; m_mar = 4'h0; m_mdr = 8'h00;
    end else if (m_mode == 0) begin
      m_ram[m_cnt] = 8'h00;
      if (m_cnt == 4'hF) m_mode = prog_mode ? 2 : 1;
      m_cnt = m_cnt + 4'd1;
    end else if (m_mode == 1) begin
      if (!ram_load_n) m_ram[m_mar] = m_mdr;
      if (!addr_load_n) m_mar = bus_in[3:0];
      if (!mem_load_n) m_mdr = bus_in;
      if (prog_mode) m_mode = 2;
    end else begin
      if (prog_valid) m_ram[prog_addr] = prog_data;
      if (!prog_mode) m_mode = 1;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    addr_load_n = 1'b1; mem_load_n = 1'b1; ram_en_n = 1'b1; ram_load_n = 1'b1;
    prog_valid = 1'b0; bus_in = 8'h00; prog_addr = 4'h0; prog_data = 8'h00;
  endtask

  task automatic check_model(input string nm);
    logic [7:0] eo;
    eo = (m_mode == 1 && !ram_en_n) ? m_ram[m_mar] : 8'h00;
    chk({nm, " busy"}, 32'(busy), 32'(m_mode == 0));
    chk({nm, " prog_ready"}, 32'(prog_ready), 32'(m_mode == 2));
    chk({nm, " bus_oe"}, 32'(bus_oe), 32'(m_mode == 1 && !ram_en_n));
    chk({nm, " bus_out"}, 32'(bus_out), 32'(eo));
    chk({nm, " mar"}, 32'(mar_out), 32'(m_mar));
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] e, input string nm);
    bus_in = {4'h0, a}; addr_load_n = 1'b0;
    step();
    addr_load_n = 1'b1; ram_en_n = 1'b0;
    #1;
    chk({nm, " oe"}, 32'(bus_oe), 32'd1);
    chk({nm, " data"}, 32'(bus_out), 32'(e));
    ram_en_n = 1'b1;
  endtask

  task automatic clear_seq();
    for (int i = 0; i < 16; i++) begin
      chk("clear busy", 32'(busy), 32'd1);
      chk("clear oe", 32'(bus_oe), 32'd0);
      step();
    end
    chk("clear done busy", 32'(busy), 32'd0);
  endtask

  initial begin
    wr_tbl = '{'{4'h0, 8'h4E}, '{4'h1, 8'h2F}, '{4'hE, 8'h05}, '{4'hF, 8'h03}};
    rd_tbl = '{'{4'h0, 8'h4E}, '{4'h1, 8'h2F}, '{4'hE, 8'h05}, '{4'hF, 8'h03},
               '{4'h2, 8'h00}, '{4'hC, 8'h00}};
    idle(); prog_mode = 1'b0; rst = 1'b1; ram_en_n = 1'b0;
    step(); step();
    chk("rst busy", 32'(busy), 32'd1);
    chk("rst prog_ready", 32'(prog_ready), 32'd0);
    chk("rst bus_oe", 32'(bus_oe), 32'd0);
    chk("rst bus_out", 32'(bus_out), 32'd0);
    chk("rst mar", 32'(mar_out), 32'd0);
    // strobes held active through the clear must be ignored
    rst = 1'b0; addr_load_n = 1'b0; mem_load_n = 1'b0; ram_load_n = 1'b0; bus_in = 8'hFF;
    clear_seq();
    chk("clear mar hold", 32'(mar_out), 32'd0);
    chk("run prog_ready", 32'(prog_ready), 32'd0);
    idle();
    for (int a = 0; a < 16; a++) rd(4'(a), 8'h00, "clear read");
    prog_valid = 1'b1; prog_addr = 4'h5; prog_data = 8'h99;
    step();
    idle();
    rd(4'h5, 8'h00, "run prog_valid ignored");
    // prog_mode held through a fresh clear lands in PROG
    rst = 1'b1; prog_mode = 1'b1;
    step();
    rst = 1'b0;
    clear_seq();
    chk("enter prog ready", 32'(prog_ready), 32'd1);
    addr_load_n = 1'b0; mem_load_n = 1'b0; ram_load_n = 1'b0; ram_en_n = 1'b0;
    bus_in = 8'h3C; prog_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      prog_addr = wr_tbl[i].addr; prog_data = wr_tbl[i].data;
      if (i == 3) prog_mode = 1'b0;
      #1;
      chk("prog ready", 32'(prog_ready), 32'd1);
      chk("prog oe", 32'(bus_oe), 32'd0);
      step();
    end
    idle();
    chk("run after prog ready", 32'(prog_ready), 32'd0);
    chk("prog mar hold", 32'(mar_out), 32'd0);
    for (int i = 0; i < 6; i++) rd(rd_tbl[i].addr, rd_tbl[i].data, "prog table read");
    // MDR must still be zero: store it over address 0
    bus_in = 8'h00; addr_load_n = 1'b0;
    step();
    addr_load_n = 1'b1; ram_load_n = 1'b0;
    step();
    ram_load_n = 1'b1;
    rd(4'h0, 8'h00, "mdr hold");
    // STA sequence
    bus_in = 8'h0E; addr_load_n = 1'b0; step(); addr_load_n = 1'b1;
    bus_in = 8'hA5; mem_load_n = 1'b0; step(); mem_load_n = 1'b1;
    ram_load_n = 1'b0; step(); ram_load_n = 1'b1;
    ram_en_n = 1'b0;
    #1;
    chk("sta oe", 32'(bus_oe), 32'd1);
    chk("sta data", 32'(bus_out), 32'hA5);
    chk("sta mar", 32'(mar_out), 32'hE);
    idle();
    // simultaneous store, read and MAR load
    bus_in = 8'h03; addr_load_n = 1'b0; step(); addr_load_n = 1'b1;
    bus_in = 8'h22; mem_load_n = 1'b0; step(); mem_load_n = 1'b1;
    ram_load_n = 1'b0; step(); ram_load_n = 1'b1;
    bus_in = 8'h11; mem_load_n = 1'b0; step(); mem_load_n = 1'b1;
    bus_in = 8'h07; ram_load_n = 1'b0; ram_en_n = 1'b0; addr_load_n = 1'b0;
    #1;
    chk("simul read old", 32'(bus_out), 32'h22);
    step();
    idle();
    chk("simul mar", 32'(mar_out), 32'h7);
    rd(4'h3, 8'h11, "simul ram new");
    // randomized against the model
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 60) == 0);
      if ($urandom_range(0, 7) == 0) prog_mode = ~prog_mode;
      {addr_load_n, mem_load_n, ram_en_n, ram_load_n} = 4'($urandom);
      prog_valid = 1'($urandom); bus_in = 8'($urandom);
      prog_addr = 4'($urandom); prog_data = 8'($urandom);
      #1;
      check_model("rand");
      step();
    end
    // reset mid-PROG wipes programmed data
    idle(); prog_mode = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    clear_seq();
    prog_mode = 1'b1;
    step();
    prog_valid = 1'b1; prog_addr = 4'h2; prog_data = 8'h55; prog_mode = 1'b0;
    step();
    idle();
    rd(4'h2, 8'h55, "prog write then run");
    prog_mode = 1'b1;
    step();
    prog_valid = 1'b1; prog_addr = 4'h2; prog_data = 8'h55;
    step();
    idle(); rst = 1'b1;
    step();
    rst = 1'b0; prog_mode = 1'b0;
    chk("mid prog rst busy", 32'(busy), 32'd1);
    clear_seq();
    rd(4'h2, 8'h00, "mid prog rst erased");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/memory_unit.md
# memory_unit

Memory stage of the 8-bit SAP-style CPU, downstream of the control block. Holds the 4-bit memory address register (MAR), the 8-bit memory data register (MDR) and a 16x8 RAM. Executes the control word bits `\L_MA`, `\L_MD`, `\CE` and `\L_R` against the shared bus. A valid/ready programming port preloads the program before execution, and a post-reset clear sequence zeroes the RAM.

## Interface
- `ADDR_W`, default 4: MAR width; RAM depth is 2^ADDR_W.
- `DATA_W`, default 8: bus, MDR and RAM word width.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `bus_in`  in  DATA_W  shared bus value; MAR loads from `bus_in[ADDR_W-1:0]`.
- `bus_out`  out  DATA_W  RAM[MAR] while driving, else 0.
- `bus_oe`  out  1  high while this block drives the bus.
- `addr_load_n`  in  1  `\L_MA`, load MAR (active-low).
- `mem_load_n`  in  1  `\L_MD`, load MDR (active-low).
- `ram_en_n`  in  1  `\CE`, drive RAM[MAR] to bus (active-low).
- `ram_load_n`  in  1  `\L_R`, write MDR to RAM[MAR] (active-low).
- `prog_mode`  in  1  request programming mode.
- `prog_valid`  in  1  programming write request.
- `prog_ready`  out  1  programming write accepted this cycle when valid.
- `prog_addr`  in  ADDR_W  programming address.
- `prog_data`  in  DATA_W  programming data.
- `busy`  out  1  high during the RAM clear sequence.
- `mar_out`  out  ADDR_W  current MAR value, for debug.

## Operation
- FSM states:
  - CLEAR (encoding 0): clear counter `clr_cnt` 0..15. Each cycle writes 0 to RAM[clr_cnt], then increments `clr_cnt`.
  - RUN: executes the control inputs.
  - PROG: accepts the programming port.
  - Any unused encoding goes to CLEAR with `clr_cnt`=0.
- Transitions:
  - CLEAR→RUN after the write of address 15 if `prog_mode`=0; CLEAR→PROG after the same write if `prog_mode`=1.
  - `prog_mode` is ignored during CLEAR.
  - RUN→PROG when `prog_mode`=1 at a rising edge.
  - PROG→RUN when `prog_mode`=0 at a rising edge.
- Reset sets: state=CLEAR, `clr_cnt`=0, MAR=0, MDR=0.
  - Reset values of outputs: `busy`=1, `prog_ready`=0, `bus_oe`=0, `bus_out`=0, `mar_out`=0.
- `busy` = (state==CLEAR). `prog_ready` = (state==PROG), combinational.
- RUN, all four actions are independent and may coincide in one cycle:
  - `addr_load_n`=0: MAR ← `bus_in[3:0]`.
  - `mem_load_n`=0: MDR ← `bus_in`.
  - `ram_load_n`=0: RAM[MAR] ← MDR. Uses the pre-edge MAR and MDR, so a write in the same cycle as a MAR or MDR load uses the old values.
  - `ram_en_n`=0: `bus_oe`=1, `bus_out`=RAM[MAR], combinational on current MAR and RAM contents. Otherwise `bus_oe`=0, `bus_out`=0.
  - Read with a simultaneous write returns the pre-write word; the new word is visible the next cycle.
- CLEAR and PROG:
  - All control inputs are ignored; MAR and MDR hold; `bus_oe`=0.
  - PROG: on `prog_valid`&&`prog_ready`, RAM[`prog_addr`] ← `prog_data`.
  - On the PROG→RUN edge, a `prog_valid` write still completes, because `prog_ready` was high that cycle.
- Reset mid-CLEAR or mid-PROG restarts CLEAR from address 0, erasing any programmed contents.

## Timing
- The control block updates the control lines on the falling edge; this block samples them on the next rising edge, giving half a cycle of setup.
- MAR, MDR and RAM writes take effect at the rising edge; latency is 1 cycle to visibility.
- Bus read has 0-cycle latency, combinational from MAR.
  - Instruction fetch: T0 loads MAR; T2 reads with `\CE`. The MAR is stable before T2.
- CLEAR takes exactly 16 cycles after `rst` deasserts; `busy` falls on the 16th edge.
- Programming throughput is 1 word per cycle. `prog_ready` rises on the edge that enters PROG.

## Test plan
- Reset, then `rst` low:
  - `busy`=1 for exactly 16 cycles, then 0.
  - Reads of all 16 addresses in RUN return 0x00.
- Programming:
  - Hold `prog_mode`=1 through CLEAR; state enters PROG after address 15.
  - Write {0:0x4E, 1:0x2F, 14:0x05, 15:0x03} back-to-back.
  - Return to RUN; bus reads at those addresses return the values; `prog_ready`=0 in RUN.
- STA sequence:
  - Bus 0x0E with `addr_load_n`=0; then bus 0xA5 with `mem_load_n`=0; then `ram_load_n`=0.
  - A following `ram_en_n`=0 gives `bus_oe`=1, `bus_out`=0xA5.
- Simultaneous events with MAR=3, MDR=0x11, RAM[3]=0x22:
  - One cycle of `ram_load_n`=`ram_en_n`=`addr_load_n`=0 with bus=0x07.
  - That cycle reads 0x22; RAM[3]=0x11 afterwards; MAR=7.
- Mode guards:
  - Control strobes during CLEAR and PROG leave MAR, MDR and RAM unchanged, and `bus_oe` stays 0.
  - `prog_valid` in RUN writes nothing.
- Reset mid-PROG after writing 0x55 to address 2: `busy` returns high, and after the clear RAM[2] reads 0x00.
